// File: rtl/sysbus_arbiter.sv
// Two-client Sysbus arbiter: fetch (client 0) and data (client 1) share one master port.
// Define SYSBUS_ARB_RR_EN for round-robin tie-break; otherwise client 1 has fixed priority.
module sysbus_arbiter #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_reqcyc,
    input  logic [DATA_W-1:0] c0_req,
    input  logic [TAG_W-1:0]  c0_reqtag,
    output logic              c0_reqack,
    output logic              c0_respcyc,
    output logic [DATA_W-1:0] c0_resp,
    input  logic              c0_respack,
    input  logic              c1_reqcyc,
    input  logic [DATA_W-1:0] c1_req,
    input  logic [TAG_W-1:0]  c1_reqtag,
    output logic              c1_reqack,
    output logic              c1_respcyc,
    output logic [DATA_W-1:0] c1_resp,
    input  logic              c1_respack,
    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    output logic              bus_respack,
    output logic              grant,
    output logic              busy,
    output logic              spurious_resp
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] g_req;
    logic [TAG_W-1:0]  g_tag;
    logic              g_respack;
    logic              in_req;
    logic              in_wd;
    logic              in_rsp;
    logic              any_req;
    logic              winner;
    logic              resp_fire;
    logic              last_beat;
    logic              done;

    assign in_req    = (state == REQ);
    assign in_wd     = (state == WDATA);
    assign in_rsp    = (state == RESP);
    assign any_req   = c0_reqcyc | c1_reqcyc;
    assign g_req     = grant ? c1_req : c0_req;
    assign g_tag     = grant ? c1_reqtag : c0_reqtag;
    assign g_respack = grant ? c1_respack : c0_respack;
    assign resp_fire = in_rsp & bus_respcyc & g_respack;
    assign last_beat = (beat_cnt == LAST);
    assign done      = (in_wd | resp_fire) & last_beat;

`ifdef SYSBUS_ARB_RR_EN
    logic rr;

    // rr names the client preferred on a tie; it alternates per completed transaction
    assign winner = (c0_reqcyc & c1_reqcyc) ? rr : c1_reqcyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (done) begin
            rr <= ~rr;
        end
    end
`else
    assign winner = c1_reqcyc;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = REQ;
            REQ:     if (bus_reqack) state_nx = g_tag[TAG_W-1] ? RESP : WDATA;
            WDATA:   if (done) state_nx = IDLE;
            RESP:    if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            grant         <= 1'b0;
            spurious_resp <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus_respcyc & ~in_rsp) spurious_resp <= 1'b1;
            if ((state == IDLE) & any_req) grant <= winner;
            if (in_wd | resp_fire) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign bus_reqcyc = in_req | in_wd;
    assign bus_req    = bus_reqcyc ? g_req : '0;
    assign bus_reqtag = bus_reqcyc ? g_tag : '0;
    assign c0_reqack  = in_req & ~grant & bus_reqack;
    assign c1_reqack  = in_req & grant & bus_reqack;

    // Beats outside RESP are drained so the bus never stalls on them
    assign bus_respack = in_rsp ? g_respack : 1'b1;
    assign c0_respcyc  = in_rsp & ~grant & bus_respcyc;
    assign c1_respcyc  = in_rsp & grant & bus_respcyc;
    assign c0_resp     = (in_rsp & ~grant) ? bus_resp : '0;
    assign c1_resp     = (in_rsp & grant) ? bus_resp : '0;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter (default fixed-priority build).
// A transaction-level model is compared against the DUT every cycle.
module tb_sysbus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          c0_reqcyc = 1'b0;
    logic [DW-1:0] c0_req = '0;
    logic [TW-1:0] c0_reqtag = '0;
    logic          c0_reqack;
    logic          c0_respcyc;
    logic [DW-1:0] c0_resp;
    logic          c0_respack = 1'b1;
    logic          c1_reqcyc = 1'b0;
    logic [DW-1:0] c1_req = '0;
    logic [TW-1:0] c1_reqtag = '0;
    logic          c1_reqack;
    logic          c1_respcyc;
    logic [DW-1:0] c1_resp;
    logic          c1_respack = 1'b1;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack = 1'b0;
    logic          bus_respcyc = 1'b0;
    logic [DW-1:0] bus_resp = '0;
    logic          bus_respack;
    logic          grant;
    logic          busy;
    logic          spurious_resp;

    sysbus_arbiter #(.DATA_W(DW), .TAG_W(TW), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .c0_reqcyc(c0_reqcyc), .c0_req(c0_req), .c0_reqtag(c0_reqtag),
        .c0_reqack(c0_reqack), .c0_respcyc(c0_respcyc), .c0_resp(c0_resp),
        .c0_respack(c0_respack),
        .c1_reqcyc(c1_reqcyc), .c1_req(c1_req), .c1_reqtag(c1_reqtag),
        .c1_reqack(c1_reqack), .c1_respcyc(c1_respcyc), .c1_resp(c1_resp),
        .c1_respack(c1_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_respack(bus_respack),
        .grant(grant), .busy(busy), .spurious_resp(spurious_resp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, whether the request was taken,
    // and how many beats of the transaction remain.
    bit m_valid = 0;
    bit m_busy, m_acc, m_read, m_spur;
    int m_own, m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1; m_busy = 0; m_own = 0; m_spur = 0; m_acc = 0; m_left = 0;
        end else if (m_valid) begin
            if (bus_respcyc && !(m_busy && m_acc && m_read)) m_spur = 1;
            if (!m_busy) begin
                if (c0_reqcyc || c1_reqcyc) begin
                    m_own = c1_reqcyc ? 1 : 0;
                    m_busy = 1; m_acc = 0;
                end
            end else if (!m_acc) begin
                if (bus_reqack) begin
                    m_acc = 1;
                    m_read = (m_own == 1) ? c1_reqtag[TW-1] : c0_reqtag[TW-1];
                    m_left = NB;
                end
            end else if (!m_read) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end else if (bus_respcyc && ((m_own == 1) ? c1_respack : c0_respack)) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
        end
    end

    logic [DW-1:0] q0[$];
    logic [DW-1:0] qw[$];
    int n1 = 0;

    always @(negedge clk) begin
        bit ph_req, ph_out, ph_rsp;
        logic [DW-1:0] e_req;
        logic [TW-1:0] e_tag;
        if (c0_respcyc && c0_respack) q0.push_back(c0_resp);
        if (c1_respcyc && c1_respack) n1++;
        if (bus_reqcyc) qw.push_back(bus_req);
        if (m_valid) begin
            ph_req = m_busy && !m_acc;
            ph_out = ph_req || (m_busy && m_acc && !m_read);
            ph_rsp = m_busy && m_acc && m_read;
            e_req = ph_out ? ((m_own == 1) ? c1_req : c0_req) : '0;
            e_tag = ph_out ? ((m_own == 1) ? c1_reqtag : c0_reqtag) : '0;
            chk("busy", busy, m_busy);
            chk("grant", grant, m_own);
            chk("spurious_resp", spurious_resp, m_spur);
            chk("bus_reqcyc", bus_reqcyc, ph_out);
            chk("bus_req", bus_req, e_req);
            chk("bus_reqtag", bus_reqtag, e_tag);
            chk("reqack", {c1_reqack, c0_reqack},
                {ph_req && m_own == 1 && bus_reqack, ph_req && m_own == 0 && bus_reqack});
            chk("respcyc", {c1_respcyc, c0_respcyc},
                {ph_rsp && m_own == 1 && bus_respcyc, ph_rsp && m_own == 0 && bus_respcyc});
            chk("c0_resp", c0_resp, (ph_rsp && m_own == 0) ? bus_resp : '0);
            chk("c1_resp", c1_resp, (ph_rsp && m_own == 1) ? bus_resp : '0);
            chk("bus_respack", bus_respack,
                ph_rsp ? ((m_own == 1) ? c1_respack : c0_respack) : 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner already granted and in REQ: ack, then stream NB read beats.
    task automatic do_read(input int who, input logic [DW-1:0] base);
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        if (who == 1) c1_reqcyc = 1'b0;
        else c0_reqcyc = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bus_respcyc = 1'b1;
            bus_resp = base + DW'(i);
            tick();
        end
        bus_respcyc = 1'b0;
    endtask

    initial begin
        int base;
        logic [DW-1:0] ev;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        logic [DW-1:0] ev;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset grant", grant, 1'b0);
        chk("reset spurious", spurious_resp, 1'b0);
        tick();

        // Single read by c0, ack after 3 REQ cycles
        c0_reqcyc = 1'b1; c0_req = 64'h1000; c0_reqtag = 13'h1005;
        tick();
        @(negedge clk);
        chk("lat bus_reqcyc", bus_reqcyc, 1'b1);
        chk("lat bus_req", bus_req, 64'h1000);
        tick(); tick(); tick();
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("c0_reqack", c0_reqack, 1'b1);
        tick();
        bus_reqack = 1'b0; c0_reqcyc = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bus_respcyc = 1'b1;
            bus_resp = DW'((i + 1) * 'h11);
            tick();
        end
        bus_respcyc = 1'b0;
        @(negedge clk);
        chk("read busy drop", busy, 1'b0);
        chk("read beats", q0.size(), NB);
        for (int i = 0; i < q0.size(); i++) begin
            ev = DW'((i + 1) * 'h11);
            chk("read beat data", q0[i], ev);
        end
        chk("read c1 beats", n1, 0);
        chk("read spurious", spurious_resp, 1'b0);
        tick();

        // Tie: fixed priority serves c1 first, then c0
        sz = q0.size();
        c0_reqcyc = 1'b1; c0_req = 64'h3000; c0_reqtag = 13'h1001;
        c1_reqcyc = 1'b1; c1_req = 64'h4000; c1_reqtag = 13'h1002;
        tick();
        @(negedge clk);
        chk("tie first grant", grant, 1'b1);
        do_read(1, 64'h100);
        @(negedge clk);
        chk("tie gap idle", busy, 1'b0);
        chk("tie c1 beats", n1, NB);
        chk("tie c0 none yet", q0.size(), sz);
        tick();
        @(negedge clk);
        chk("tie second grant", grant, 1'b0);
        chk("tie second busy", busy, 1'b1);
        do_read(0, 64'h200);
        @(negedge clk);
        chk("tie c0 beats", q0.size(), sz + NB);
        chk("tie c0 first", q0[sz], 64'h200);
        tick();

        // Write by c1
        qw.delete();
        c1_reqcyc = 1'b1; c1_req = 64'h2000; c1_reqtag = 13'h0023;
        tick(); tick();
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0; c1_reqcyc = 1'b0;
        for (int i = 0; i < NB; i++) begin
            c1_req = 64'hA0 + DW'(i);
            tick();
        end
        @(negedge clk);
        chk("write busy drop", busy, 1'b0);
        chk("write bus beats", qw.size(), 10);
        if (qw.size() == 10) begin
            chk("write addr 0", qw[0], 64'h2000);
            chk("write addr 1", qw[1], 64'h2000);
            for (int i = 0; i < NB; i++) begin
                ev = 64'hA0 + DW'(i);
                chk("write data", qw[2+i], ev);
            end
        end
        chk("write no resp", n1, NB);
        tick();

        // Backpressure: beats index 2 and 3 stalled 2 cycles each
        sz = q0.size();
        c0_reqcyc = 1'b1; c0_req = 64'h5000; c0_reqtag = 13'h1007;
        tick();
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0; c0_reqcyc = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bus_respcyc = 1'b1;
            bus_resp = 64'h300 + DW'(i);
            if (i == 2 || i == 3) begin
                c0_respack = 1'b0;
                @(negedge clk);
                chk("stall respack", bus_respack, 1'b0);
                tick(); tick();
                c0_respack = 1'b1;
            end
            tick();
        end
        bus_respcyc = 1'b0;
        @(negedge clk);
        chk("bp busy", busy, 1'b0);
        chk("bp beats", q0.size(), sz + NB);
        for (int i = 0; i < NB && sz + i < q0.size(); i++) begin
            ev = 64'h300 + DW'(i);
            chk("bp data", q0[sz+i], ev);
        end
        tick();

        // Reset after 4 beats; the rest must be drained, not forwarded
        sz = q0.size();
        c0_reqcyc = 1'b1; c0_req = 64'h6000; c0_reqtag = 13'h1008;
        tick();
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0; c0_reqcyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_respcyc = 1'b1;
            bus_resp = 64'h400 + DW'(i);
            tick();
        end
        bus_respcyc = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst spurious clear", spurious_resp, 1'b0);
        for (int i = 4; i < NB; i++) begin
            bus_respcyc = 1'b1;
            bus_resp = 64'h400 + DW'(i);
            @(negedge clk);
            chk("rst drain respack", bus_respack, 1'b1);
            chk("rst no fwd", c0_respcyc, 1'b0);
            tick();
        end
        bus_respcyc = 1'b0;
        @(negedge clk);
        chk("rst spurious", spurious_resp, 1'b1);
        chk("rst c0 beats", q0.size(), sz + 4);
        tick();

        // Spurious beat while idle, sticky until reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("spur pre", spurious_resp, 1'b0);
        tick();
        bus_respcyc = 1'b1; bus_resp = 64'hDEAD;
        @(negedge clk);
        chk("spur respack", bus_respack, 1'b1);
        tick();
        bus_respcyc = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("spur sticky", spurious_resp, 1'b1);
        chk("spur busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("spur cleared", spurious_resp, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
